// File: rtl/fdiv_arbiter.sv
// Shares one half-precision divider among NREQ requesters with a five-state handshake FSM.
// Define FDIV_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module fdiv_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [15:0]          resp_z,
  input  logic [NREQ-1:0]      resp_ready,
  output logic                 busy,
  output logic [PTR_W-1:0]     grant_id,
  output logic [15:0]          div_a,
  output logic [15:0]          div_b,
  output logic                 div_a_stb,
  output logic                 div_b_stb,
  input  logic                 div_a_ack,
  input  logic                 div_b_ack,
  input  logic [15:0]          div_z,
  input  logic                 div_z_stb,
  output logic                 div_z_ack
);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;

  state_t           state_reg, state_next;
  logic [15:0]      a_reg, b_reg, z_reg;
  logic [PTR_W-1:0] grant_reg;
  logic [PTR_W-1:0] winner;
  logic             any_req;
  logic             grant_fire;

  logic [15:0] a_arr [NREQ];
  logic [15:0] b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_arr[gi] = req_a[16*gi +: 16];
    assign b_arr[gi] = req_b[16*gi +: 16];
  end

`ifdef FDIV_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest requesting index is the last one written.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[PTR_W'(k)]) begin
        winner  = PTR_W'(k);
        any_req = 1'b1;
      end
    end
  end
`else
  logic [PTR_W-1:0] last_grant_reg;

  // Offset NREQ (the last winner itself) is lowest priority, offset 1 highest.
  always_comb begin
    int sum;
    sum     = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      sum = int'(last_grant_reg) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      if (req_valid[PTR_W'(sum)]) begin
        winner  = PTR_W'(sum);
        any_req = 1'b1;
      end
    end
  end
`endif

  assign grant_fire = (state_reg == IDLE) && any_req && !rst;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req)                state_next = SEND_A;
      SEND_A:  if (div_a_ack)              state_next = SEND_B;
      SEND_B:  if (div_b_ack)              state_next = WAIT_Z;
      WAIT_Z:  if (div_z_stb)              state_next = RESP;
      RESP:    if (resp_ready[grant_reg])  state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (grant_fire)          req_ready[winner]     = 1'b1;
    if (state_reg == RESP)   resp_valid[grant_reg] = 1'b1;
  end

  assign div_a_stb = (state_reg == SEND_A);
  assign div_b_stb = (state_reg == SEND_B);
  assign div_z_ack = (state_reg == WAIT_Z);
  assign busy      = (state_reg != IDLE);
  assign grant_id  = grant_reg;
  assign resp_z    = z_reg;
  assign div_a     = a_reg;
  assign div_b     = b_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      z_reg          <= '0;
      grant_reg      <= '0;
`ifndef FDIV_ARB_FIXED_PRIO_EN
      last_grant_reg <= PTR_W'(NREQ - 1);
`endif
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && any_req) begin
        a_reg          <= a_arr[winner];
        b_reg          <= b_arr[winner];
        grant_reg      <= winner;
`ifndef FDIV_ARB_FIXED_PRIO_EN
        last_grant_reg <= winner;
`endif
      end
      if (state_reg == WAIT_Z && div_z_stb) z_reg <= div_z;
    end
  end

endmodule

// File: tb/tb_fdiv_arbiter.sv
// Bench for fdiv_arbiter: behavioural divider, scoreboard monitor and directed/random scenarios.
module tb_fdiv_arbiter;
  localparam int NREQ  = 4;
  localparam int PTR_W = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [16*NREQ-1:0]  req_a, req_b;
  logic [15:0]         resp_z, div_a, div_b, div_z;
  logic                busy;
  logic [PTR_W-1:0]    grant_id;
  logic                div_a_stb, div_b_stb, div_a_ack, div_b_ack, div_z_stb, div_z_ack;

  always #5 clk = ~clk;

  fdiv_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_z(resp_z), .resp_ready(resp_ready),
    .busy(busy), .grant_id(grant_id), .div_a(div_a), .div_b(div_b),
    .div_a_stb(div_a_stb), .div_b_stb(div_b_stb), .div_a_ack(div_a_ack), .div_b_ack(div_b_ack),
    .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack)
  );

  int vectors = 0, miscompares = 0;
  int a_delay = 0, b_delay = 0, z_lat = 0;
  int grant_log[$];
  int resp_id_log[$];
  logic [15:0] resp_log[$];
  int grant_count = 0, resp_count = 0, a_stb_cycles = 0;

  // Divider behaviour: exact quotients for the known vectors, a fixed scramble otherwise.
  function automatic logic [15:0] div_ref(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: return 16'h3800;
      32'h4600_4200: return 16'h4000;
      32'h3C00_0000: return 16'h7C00;
      32'h7E00_3C00: return 16'h7E00;
      default:       return {a[7:0] ^ b[15:8], a[15:8] + b[7:0]};
    endcase
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef FDIV_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return -1;
  endfunction

  // Divider model: acts on falling edges so its strobes/acks are stable at rising edges.
  int d_state = 0, d_cnt = 0;
  logic [15:0] d_op_a, d_op_b;
  initial begin
    div_a_ack = 0; div_b_ack = 0; div_z_stb = 0; div_z = '0; d_op_a = '0; d_op_b = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        d_state = 0; d_cnt = 0; div_a_ack = 0; div_b_ack = 0; div_z_stb = 0;
      end else begin
        case (d_state)
          0: if (div_a_stb) begin
               if (d_cnt < a_delay) d_cnt++;
               else begin div_a_ack = 1; d_op_a = div_a; d_state = 1; end
             end
          1: begin div_a_ack = 0; d_cnt = 0; d_state = 2; end
          2: if (div_b_stb) begin
               if (d_cnt < b_delay) d_cnt++;
               else begin div_b_ack = 1; d_op_b = div_b; d_state = 3; end
             end
          3: begin div_b_ack = 0; d_cnt = 0; d_state = 4; end
          4: if (d_cnt < z_lat) d_cnt++;
             else begin div_z = div_ref(d_op_a, d_op_b); div_z_stb = 1; d_state = 5; end
          default: begin div_z_stb = 0; d_cnt = 0; d_state = 0; end
        endcase
      end
    end
  end

  // Scoreboard: tracks the operation in flight from the arbitration rules.
  int m_last = NREQ - 1, m_id = 0, m_exp;
  logic m_inflight = 1'b0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [NREQ-1:0] m_vec;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_last = NREQ - 1; m_inflight = 1'b0;
      end else begin
        if (div_a_stb) a_stb_cycles++;
        if (req_ready !== '0 || (busy === 1'b0 && req_valid != '0)) begin
          m_exp = pick(req_valid, m_last);
          m_vec = '0;
          if (m_exp >= 0) m_vec[m_exp] = 1'b1;
          vectors++;
          if (m_exp < 0 || req_ready !== m_vec || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL grant: req_ready=%b busy=%b, required req_ready=%b busy=0 (req_valid=%b)",
                     req_ready, busy, m_vec, req_valid);
          end
          if (m_exp >= 0) begin
            m_id = m_exp; m_a = req_a[16*m_exp +: 16]; m_b = req_b[16*m_exp +: 16];
            m_inflight = 1'b1; m_last = m_exp;
            grant_log.push_back(m_exp); grant_count++;
          end
        end
        if (div_a_stb) begin
          vectors++;
          if (!m_inflight || div_a !== m_a || div_b_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL div_a: div_a=%h b_stb=%b, required %h b_stb=0", div_a, div_b_stb, m_a);
          end
        end
        if (div_b_stb) begin
          vectors++;
          if (!m_inflight || div_b !== m_b) begin
            miscompares++;
            $display("FAIL div_b: div_b=%h, required %h", div_b, m_b);
          end
        end
        if (resp_valid !== '0) begin
          m_vec = '0; m_vec[m_id] = 1'b1;
          vectors++;
          if (!m_inflight || resp_valid !== m_vec || resp_z !== div_ref(m_a, m_b) ||
              grant_id !== m_id[PTR_W-1:0]) begin
            miscompares++;
            $display("FAIL resp: resp_valid=%b z=%h id=%0d, required %b z=%h id=%0d",
                     resp_valid, resp_z, grant_id, m_vec, div_ref(m_a, m_b), m_id);
          end
          if (resp_ready[m_id]) begin
            resp_log.push_back(resp_z); resp_id_log.push_back(m_id); resp_count++;
            m_inflight = 1'b0;
            $display("txn req=%0d a=%h b=%h z=%h", m_id, m_a, m_b, resp_z);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic run_one(input int i, input logic [15:0] a, input logic [15:0] b);
    int g0, r0;
    g0 = grant_count; r0 = resp_count;
    set_req(i, a, b); req_valid[i] = 1'b1;
    for (int c = 0; c < 200 && grant_count == g0; c++) tick();
    req_valid = '0;
    for (int c = 0; c < 300 && resp_count == r0; c++) tick();
    vectors++;
    if (resp_count !== r0 + 1 || resp_id_log[$] !== i) begin
      miscompares++;
      $display("FAIL run_one: responses=%0d id=%0d, required %0d id=%0d",
               resp_count - r0, resp_id_log[$], 1, i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; resp_ready = '1; tick(); tick();
    vectors++;
    if ({req_ready, resp_valid} !== '0) begin
      miscompares++; $display("FAIL reset_hs: req_ready=%b resp_valid=%b, required 0", req_ready, resp_valid);
    end
    vectors++;
    if ({div_a_stb, div_b_stb, div_z_ack, busy} !== 4'b0) begin
      miscompares++; $display("FAIL reset_ctl: a_stb,b_stb,z_ack,busy=%b, required 0000",
                              {div_a_stb, div_b_stb, div_z_ack, busy});
    end
    vectors++;
    if (grant_id !== '0 || resp_z !== 16'h0) begin
      miscompares++; $display("FAIL reset_regs: grant_id=%0d resp_z=%h, required 0 0000", grant_id, resp_z);
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_single();
    run_one(0, 16'h3C00, 16'h4000);
    vectors++;
    if (grant_log[$] !== 0 || resp_log[$] !== 16'h3800) begin
      miscompares++; $display("FAIL single: grant=%0d z=%h, required 0 3800", grant_log[$], resp_log[$]);
    end
  endtask

  task automatic test_all_four();
    int g0, r0;
    int exp_order[5];
`ifdef FDIV_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    g0 = grant_count; r0 = resp_count;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'h4600, 16'h4200);
    req_valid = '1;
    for (int c = 0; c < 500 && resp_count < r0 + 5; c++) tick();
    req_valid = '0;
    tick();
    vectors++;
    if (grant_count !== g0 + 5 || resp_count !== r0 + 5) begin
      miscompares++; $display("FAIL all4_count: grants=%0d resps=%0d, required 5 5", grant_count - g0, resp_count - r0);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (grant_log[g0 + k] !== exp_order[k] || resp_log[r0 + k] !== 16'h4000) begin
        miscompares++; $display("FAIL all4_order: grant[%0d]=%0d z=%h, required %0d 4000",
                                k, grant_log[g0 + k], resp_log[r0 + k], exp_order[k]);
      end
    end
  endtask

  task automatic test_stall();
    int g0;
    logic [15:0] a;
    a = 16'($urandom); g0 = grant_count;
    a_delay = 10; a_stb_cycles = 0;
    set_req(1, a, 16'($urandom)); req_valid[1] = 1'b1;
    for (int c = 0; c < 200 && grant_count == g0; c++) tick();
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (div_a_stb !== 1'b1 || div_b_stb !== 1'b0 || div_a !== a) begin
        miscompares++; $display("FAIL stall_c%0d: a_stb=%b b_stb=%b div_a=%h, required 1 0 %h",
                                c, div_a_stb, div_b_stb, div_a, a);
      end
    end
    for (int c = 0; c < 200 && busy; c++) tick();
    a_delay = 0;
    vectors++;
    if (a_stb_cycles !== 11) begin
      miscompares++; $display("FAIL stall_len: a_stb cycles=%0d, required 11", a_stb_cycles);
    end
  endtask

  task automatic test_backpressure();
    int g0;
    logic [15:0] a, b;
    a = 16'($urandom); b = 16'($urandom); g0 = grant_count;
    set_req(2, a, b); req_valid = 4'b0100;
    for (int c = 0; c < 200 && grant_count == g0; c++) tick();
    for (int i = 0; i < NREQ; i++) if (i != 2) set_req(i, 16'($urandom), 16'($urandom));
    req_valid = 4'b1011; resp_ready = 4'b1011;
    for (int c = 0; c < 200 && resp_valid === '0; c++) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      vectors++;
      if (resp_valid !== 4'b0100 || resp_z !== div_ref(a, b) || req_ready !== '0) begin
        miscompares++; $display("FAIL bp_c%0d: resp_valid=%b z=%h req_ready=%b, required 0100 %h 0000",
                                c, resp_valid, resp_z, req_ready, div_ref(a, b));
      end
      @(negedge clk);
    end
    tick(); resp_ready = '1;
    for (int c = 0; c < 200 && grant_count < g0 + 2; c++) tick();
    req_valid = '0;
    for (int c = 0; c < 300 && busy; c++) tick();
    vectors++;
`ifdef FDIV_ARB_FIXED_PRIO_EN
    if (grant_log[g0 + 1] !== 0) begin
`else
    if (grant_log[g0 + 1] !== 3) begin
`endif
      miscompares++; $display("FAIL bp_next: next grant=%0d, required %0d", grant_log[g0 + 1],
`ifdef FDIV_ARB_FIXED_PRIO_EN
                              0);
`else
                              3);
`endif
    end
  endtask

  task automatic test_special();
    run_one(3, 16'h3C00, 16'h0000);
    vectors++;
    if (resp_log[$] !== 16'h7C00) begin
      miscompares++; $display("FAIL inf: z=%h, required 7c00", resp_log[$]);
    end
    run_one(1, 16'h7E00, 16'h3C00);
    vectors++;
    if (resp_log[$][14:10] !== 5'd31 || resp_log[$][9:0] === 10'd0) begin
      miscompares++; $display("FAIL nan: z=%h, required exp 31 and mantissa nonzero", resp_log[$]);
    end
  endtask

  task automatic test_reset_in_wait();
    int g0, r0;
    g0 = grant_count; r0 = resp_count; z_lat = 30;
    set_req(3, 16'($urandom), 16'($urandom)); req_valid[3] = 1'b1;
    for (int c = 0; c < 200 && grant_count == g0; c++) tick();
    req_valid = '0;
    for (int c = 0; c < 200 && div_z_ack !== 1'b1; c++) @(negedge clk);
    tick(); rst = 1'b1; tick();
    vectors++;
    if ({busy, div_z_ack, div_a_stb, div_b_stb} !== 4'b0 || resp_valid !== '0 || req_ready !== '0 ||
        grant_id !== '0 || resp_z !== 16'h0) begin
      miscompares++; $display("FAIL rst_wait: busy=%b z_ack=%b resp_valid=%b grant_id=%0d resp_z=%h, required all 0",
                              busy, div_z_ack, resp_valid, grant_id, resp_z);
    end
    tick(); rst = 1'b0; z_lat = 2;
    for (int c = 0; c < 40; c++) tick();
    vectors++;
    if (resp_count !== r0) begin
      miscompares++; $display("FAIL rst_abandon: responses=%0d, required 0", resp_count - r0);
    end
    run_one(1, 16'h3C00, 16'h4000);
    vectors++;
    if (resp_log[$] !== 16'h3800 || grant_log[$] !== 1) begin
      miscompares++; $display("FAIL rst_after: z=%h grant=%0d, required 3800 1", resp_log[$], grant_log[$]);
    end
    z_lat = 0;
  endtask

  task automatic test_random();
    int g0, r0;
    g0 = grant_count; r0 = resp_count;
    for (int c = 0; c < 1500; c++) begin
      req_valid  = NREQ'($urandom);
      req_a      = {$urandom, $urandom};
      req_b      = {$urandom, $urandom};
      resp_ready = NREQ'($urandom) | NREQ'($urandom);
      a_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3); z_lat = $urandom_range(0, 4);
      tick();
    end
    req_valid = '0; resp_ready = '1;
    for (int c = 0; c < 300 && busy; c++) tick();
    tick();
    vectors++;
    if (busy !== 1'b0 || grant_count - g0 !== resp_count - r0 || grant_count - g0 < 20) begin
      miscompares++; $display("FAIL random_drain: busy=%b grants=%0d resps=%0d, required 0 and equal (>=20)",
                              busy, grant_count - g0, resp_count - r0);
    end
    a_delay = 0; b_delay = 0; z_lat = 0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = '1;
    test_reset();
    test_single();
    test_all_four();
    test_stall();
    test_backpressure();
    test_special();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fdiv_arbiter.md
FDIV_ARBITER -- requirements
Module: fdiv_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing one half-precision divider (2..8).
REQ-002 Parameter: PTR_W, default 2, width of the grant index (clog2(NREQ)).
REQ-003 The block SHALL use clk as its clock and rst as its reset; reset rst is synchronous and active-high.
REQ-004 Ports, in order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester operation request.
- req_a  in  16*NREQ  dividend per requester (slice i = bits 16i+15:16i).
- req_b  in  16*NREQ  divisor per requester.
- req_ready  out  NREQ  one-hot, one-cycle operand-accept pulse.
- resp_valid  out  NREQ  one-hot result-valid for the granted requester.
- resp_z  out  16  quotient.
- resp_ready  in  NREQ  per-requester result accept.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  PTR_W  index of the current or most recent grant.
- div_a, div_b  out  16 each  operands to the divider.
- div_a_stb, div_b_stb  out  1 each  operand strobes.
- div_a_ack, div_b_ack  in  1 each  divider operand acks.
- div_z  in  16  divider result.
- div_z_stb  in  1  divider result strobe.
- div_z_ack  out  1  result ack to the divider.

Function
REQ-005 FSM states SHALL be IDLE, SEND_A, SEND_B, WAIT_Z and RESP, with exactly one state active per cycle.
REQ-006 IDLE: if any req_valid bit is set, the block SHALL select a winner, register its req_a/req_b and index, pulse req_ready[winner] for exactly that cycle, and go to SEND_A. If no bit is set, it SHALL stay in IDLE.
REQ-007 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NREQ and wraps. last_grant resets to NREQ-1, so requester 0 wins first.
REQ-008 SEND_A: div_a and div_a_stb=1 SHALL be driven; on a cycle where div_a_stb and div_a_ack are both high, div_a_stb SHALL drop next cycle and the FSM SHALL go to SEND_B.
REQ-009 SEND_B: same rule as SEND_A using div_b, div_b_stb and div_b_ack; the FSM SHALL then go to WAIT_Z.
REQ-010 WAIT_Z: div_z_ack SHALL be held at 1. On a cycle where div_z_stb and div_z_ack are both high, div_z SHALL be captured into resp_z, div_z_ack SHALL drop next cycle, and the FSM SHALL go to RESP.
REQ-011 RESP: resp_valid[grant_id] SHALL be 1 with resp_z stable. When resp_ready[grant_id] is high, the FSM SHALL return to IDLE next cycle and clear resp_valid. resp_ready bits of other requesters SHALL be ignored.
REQ-012 A new request SHALL NOT be granted before the IDLE cycle following RESP (no overlap). Minimum spacing between grants is therefore 5 cycles plus divider latency.
REQ-013 Operands SHALL be passed unmodified. NaN, inf and zero handling is the divider's responsibility; the arbiter performs no arithmetic.
REQ-014 A req_valid deasserted before its grant SHALL be dropped silently. req_valid changes after the req_ready pulse SHALL NOT affect the operation in flight.
REQ-015 Simultaneous requests: exactly one req_ready bit SHALL pulse; losers remain pending.

Reset
REQ-016 On rst, next cycle: state=IDLE; req_ready, resp_valid, div_a_stb, div_b_stb, div_z_ack = 0; busy=0; grant_id=0; resp_z=0; last_grant=NREQ-1.
REQ-017 rst SHALL be wired to the divider's reset. A reset in any state SHALL abandon the operation with no response issued.

Configuration
REQ-018 Macro FDIV_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (lowest index wins) and last_grant SHALL be unused. When undefined, round-robin per REQ-007 applies.

Verification
REQ-019 Single request: req 0, a=0x3C00, b=0x4000 -> req_ready[0] pulse, resp_valid[0], resp_z=0x3800.
REQ-020 All four requesters valid continuously, each with a=0x4600, b=0x4200 -> grants in order 0,1,2,3,0; every resp_z=0x4000; with the macro defined, grants are 0,0,0...
REQ-021 Divider stalls: div_a_ack held 0 for 10 cycles -> div_a_stb held 1 and div_a stable, no state change.
REQ-022 Backpressure: resp_ready[2]=0 for 20 cycles -> resp_valid[2] and resp_z held; no new req_ready pulse during the stall.
REQ-023 Special value: a=0x3C00, b=0x0000 -> resp_z=0x7C00; a=0x7E00 (NaN), b=0x3C00 -> resp_z exponent=31 and mantissa≠0.
REQ-024 rst asserted in WAIT_Z -> next cycle all outputs per REQ-016, no resp_valid; the next request completes correctly.
